// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one single-port memory.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data beats fetch.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_read_req,
    input  logic              d_write_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       sel_d, any_req, grant, sample, pick_d;
    assign any_req = if_req | d_read_req | d_write_req;
    assign grant   = state == IDLE && any_req;
    assign sample  = state == WAIT && cnt == 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
    assign pick_d = (d_read_req | d_write_req) & (~if_req | ~last_d);
    always_ff @(posedge clk or posedge reset)
        if (reset) last_d <= 1'b0;
        else if (grant) last_d <= pick_d;
`else
    assign pick_d = d_read_req | d_write_req;
`endif
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:  state_n = any_req ? ISSUE : IDLE;
            ISSUE: begin
                state_n = mem_we ? RESP : WAIT;
                cnt_n   = 4'(MEM_LATENCY - 1);
            end
            WAIT: begin
                state_n = sample ? RESP : WAIT;
                cnt_n   = sample ? cnt : cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            sel_d     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mem_en  <= grant;
            mem_we  <= grant & pick_d & d_write_req;
            if_done <= state_n == RESP && !sel_d;
            d_done  <= state_n == RESP && sel_d;
            if (grant) begin
                sel_d    <= pick_d;
                mem_addr <= pick_d ? d_addr : if_addr;
                if (pick_d) mem_wdata <= d_wdata;
            end
            if (sample && sel_d) d_rdata <= mem_rdata;
            if (sample && !sel_d) if_rdata <= mem_rdata;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-timeline model of the arbiter plus a memory model driving mem_rdata.
module tb_mem_port_arbiter;
    localparam int LAT = 3;
    logic        clk = 1'b0, reset = 1'b1;
    logic        if_req, if_done, d_read_req, d_write_req, d_done, mem_en, mem_we;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_read_req(d_read_req), .d_write_req(d_write_req), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, cyc = 0, rd_cyc = -1;
    logic [31:0] ram [16];
    logic [31:0] ref_mem [16];
    logic [3:0]  rd_a = 4'd0;
    bit          if_pend = 0, d_pend = 0, rand_mode = 0;
    logic [1:0]  d_kind = 2'd0;
    logic [31:0] if_a = 0, d_a = 0, d_wd = 0;
    bit          busy = 0, win_d = 0, is_wr = 0, last_d = 0;
    int          k = 0, dur = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, rd_val = 0, exp_if_rdata = 0, exp_d_rdata = 0;
    int          if_done_cyc = 0, d_done_cyc = 0, if_done_n = 0, d_done_n = 0;
    int          if_grant_cyc = 0, d_grant_cyc = 0, t0 = 0, n0 = 0;
    logic [31:0] seen_waddr = 0, seen_wdata = 0, seen_if_rdata = 0, seen_d_rdata = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_done"}, if_done, 0);
        chk({tag, "_d_done"}, d_done, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        busy = 0;
        last_d = 0;
        exp_if_rdata = 0;
        exp_d_rdata = 0;
        rd_cyc = -1;
    endtask

    // Compare the current cycle, then play the memory's part.
    task automatic check();
        bit e_en, e_fin;
        @(negedge clk);
        cyc++;
        e_en  = busy && k == 1;
        e_fin = busy && k == dur;
        if (e_fin && !is_wr) begin
            if (win_d) exp_d_rdata = rd_val;
            else exp_if_rdata = rd_val;
        end
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_en && is_wr);
        chk("if_done", if_done, e_fin && !win_d);
        chk("d_done", d_done, e_fin && win_d);
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (e_en) chk("mem_addr", mem_addr, m_addr);
        if (e_en && is_wr) chk("mem_wdata", mem_wdata, m_wdata);
        if (if_done) begin
            if_done_cyc = cyc;
            if_done_n++;
            seen_if_rdata = if_rdata;
        end
        if (d_done) begin
            d_done_cyc = cyc;
            d_done_n++;
            seen_d_rdata = d_rdata;
        end
        if (mem_en && mem_we) begin
            seen_waddr = mem_addr;
            seen_wdata = mem_wdata;
            ram[mem_addr[5:2]] = mem_wdata;
        end
        if (mem_en && !mem_we) begin
            rd_cyc = cyc + LAT;
            rd_a = mem_addr[5:2];
        end
        mem_rdata = (cyc == rd_cyc) ? ram[rd_a] : $urandom;
    endtask

    // Update requesters and the timeline model for the coming clock edge.
    task automatic advance();
        if (busy && k == dur) begin
            if (win_d) d_pend = 0;
            else if_pend = 0;
        end
        if (rand_mode) begin
            if (!if_pend && $urandom_range(2) == 0) begin
                if_pend = 1;
                if_a = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend = 1;
                d_kind = 2'($urandom_range(2));
                d_a = $urandom & 32'hFFFF_FFFC;
                d_wd = $urandom;
            end
        end
        if_req = if_pend;
        if_addr = if_a;
        d_read_req = d_pend && d_kind != 2'd1;
        d_write_req = d_pend && d_kind != 2'd0;
        d_addr = d_a;
        d_wdata = d_wd;
        if (busy) begin
            if (k == dur) busy = 0;
            else k++;
        end else if (if_pend || d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d = d_pend && (!if_pend || !last_d);
`else
            win_d = d_pend;
`endif
            last_d = win_d;
            busy = 1;
            k = 1;
            is_wr = win_d && d_kind != 2'd0;
            m_addr = win_d ? d_a : if_a;
            dur = is_wr ? 2 : 2 + LAT;
            if (is_wr) begin
                m_wdata = d_wd;
                ref_mem[d_a[5:2]] = d_wd;
            end else rd_val = ref_mem[m_addr[5:2]];
            if (win_d) d_grant_cyc = cyc;
            else if_grant_cyc = cyc;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            check();
            advance();
        end
    endtask

    initial begin
        if_req = 0; if_addr = 0; d_read_req = 0; d_write_req = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        for (int i = 0; i < 16; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[0] = 32'h0050_0093;
        ref_mem[0] = 32'h0050_0093;
        repeat (2) @(negedge clk);
        zero_chk("rst");
        reset = 0;
        advance();
        // Done lands 2 cycles after the grant edge for writes and 2+LAT for reads.
        if_pend = 1; if_a = 32'h100;
        advance();
        run(8);
        chk("fetch_rdata", seen_if_rdata, 32'h0050_0093);
        chk("fetch_lat", if_done_cyc - if_grant_cyc, 5);
        chk("fetch_if_cnt", if_done_n, 1);
        chk("fetch_d_cnt", d_done_n, 0);
        d_pend = 1; d_kind = 2'd1; d_a = 32'h2004; d_wd = 32'hDEAD_BEEF;
        advance();
        run(5);
        chk("wr_addr", seen_waddr, 32'h2004);
        chk("wr_data", seen_wdata, 32'hDEAD_BEEF);
        chk("wr_lat", d_done_cyc - d_grant_cyc, 2);
        d_pend = 1; d_kind = 2'd0;
        advance();
        run(8);
        chk("rd_back", seen_d_rdata, 32'hDEAD_BEEF);
        chk("rd_lat", d_done_cyc - d_grant_cyc, 5);
        t0 = cyc;
        if_pend = 1; if_a = 32'h100; d_pend = 1; d_kind = 2'd0; d_a = 32'h2004;
        advance();
        run(14);
`ifdef ARB_ROUND_ROBIN_EN
        chk("coll_if_first", if_done_cyc - t0, 5);
        chk("coll_d_second", d_done_cyc - t0, 11);
`else
        chk("coll_d_first", d_done_cyc - t0, 5);
        chk("coll_if_second", if_done_cyc - t0, 11);
`endif
        chk("coll_if_rdata", seen_if_rdata, 32'h0050_0093);
        chk("coll_d_rdata", seen_d_rdata, 32'hDEAD_BEEF);
        if_pend = 1; if_a = 32'h40;
        advance();
        run(2);
        @(posedge clk);
        #2 reset = 1;
        #1 zero_chk("mid");
        n0 = if_done_n;
        repeat (2) @(negedge clk);
        chk("rst_no_done", if_done_n - n0, 0);
        reset = 0;
        advance();
        run(8);
        chk("regrant_once", if_done_n - n0, 1);
        chk("regrant_lat", if_done_cyc - if_grant_cyc, 5);
        chk("regrant_rdata", seen_if_rdata, 32'h0050_0093);
        rand_mode = 1;
        run(3000);
        rand_mode = 0;
        run(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
